// File: rtl/binop_frame_sequencer.sv
// Frame sequencer for the 9x9 binary operator. It paces input rows with gaps and padding rows,
// then removes the operator's warm-up rows from the result stream.
module binop_frame_sequencer #(
    parameter int WB       = 11,
    parameter int HB       = 10,
    parameter int HGAP     = 20,
    parameter int PAD_ROWS = 4
) (
    input  logic          clk,
    input  logic          SRST,
    input  logic          Start,
    input  logic [WB-1:0] Width,
    input  logic [HB-1:0] Height,
    input  logic          InValid,
    input  logic          InPixel,
    output logic          InReady,
    output logic          OpDataEn,
    output logic          OpPixel,
    input  logic          OpDataOutEn,
    input  logic          OpResult,
    output logic          OutEn,
    output logic          OutPixel,
    output logic          OutLast,
    output logic          FrameDone,
    output logic          Busy,
    output logic          Underflow
);
    localparam int GB  = $clog2(HGAP);
    localparam int PRB = (PAD_ROWS > 1) ? $clog2(PAD_ROWS) : 1;
    localparam int ORB = HB + 1;

    typedef enum logic [2:0] {IDLE, GAP, ROW, PGAP, PROW, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [WB-1:0]  width_q, width_d, col_q, col_d, ocol_q, ocol_d;
    logic [HB-1:0]  height_q, height_d, row_q, row_d;
    logic [PRB-1:0] prow_q, prow_d;
    logic [GB-1:0]  gcnt_q, gcnt_d;
    logic [ORB-1:0] orow_q, orow_d;
    logic           op_en_q, op_en_d, op_pix_q, op_pix_d;
    logic           underflow_q, underflow_d, busy_q, busy_d;
    logic           frame_done_q, frame_done_d;
    logic           dout_prev_q, dout_prev_d, out_done_q, out_done_d;

    logic gap_last, col_last, dout_fall, done_evt, out_pass;

    always_comb begin
        gap_last  = (gcnt_q == GB'(HGAP - 1));
        col_last  = (col_q == width_q - WB'(1));
        dout_fall = busy_q && dout_prev_q && !OpDataOutEn;
        done_evt  = dout_fall && (orow_q == ORB'(PAD_ROWS) + ORB'(height_q) - ORB'(1));
        // Warm-up rows are dropped, and so are any pixels past Width in an over-long row.
        out_pass  = busy_q && (orow_q >= ORB'(PAD_ROWS)) && (ocol_q != width_q);
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        col_d        = col_q;
        row_d        = row_q;
        prow_d       = prow_q;
        gcnt_d       = gcnt_q;
        op_en_d      = 1'b0;
        op_pix_d     = 1'b0;
        underflow_d  = underflow_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        dout_prev_d = busy_q && OpDataOutEn;
        orow_d      = dout_fall ? orow_q + ORB'(1) : orow_q;
        out_done_d  = out_done_q || done_evt;
        if (!busy_q || !OpDataOutEn) begin
            ocol_d = '0;
        end else if (ocol_q != width_q) begin
            ocol_d = ocol_q + WB'(1);
        end else begin
            ocol_d = ocol_q;
        end

        case (state_q)
            IDLE: begin
                // The cycle FrameDone is high still counts as busy for Start.
                if (Start && !frame_done_q) begin
                    width_d     = Width;
                    height_d    = Height;
                    underflow_d = 1'b0;
                    busy_d      = 1'b1;
                    row_d       = '0;
                    gcnt_d      = '0;
                    orow_d      = '0;
                    ocol_d      = '0;
                    out_done_d  = 1'b0;
                    state_d     = GAP;
                end
            end
            GAP, PGAP: begin
                if (gap_last) begin
                    gcnt_d  = '0;
                    col_d   = '0;
                    state_d = (state_q == GAP) ? ROW : PROW;
                end else begin
                    gcnt_d = gcnt_q + GB'(1);
                end
            end
            ROW: begin
                // The operator needs contiguous rows, so a missing pixel becomes 0.
                op_en_d  = 1'b1;
                op_pix_d = InValid && InPixel;
                if (!InValid) underflow_d = 1'b1;
                col_d = col_q + WB'(1);
                if (col_last) begin
                    col_d  = '0;
                    row_d  = row_q + HB'(1);
                    gcnt_d = '0;
                    if (row_q != height_q - HB'(1)) begin
                        state_d = GAP;
                    end else if (PAD_ROWS == 0) begin
                        state_d = DRAIN;
                    end else begin
                        prow_d  = '0;
                        state_d = PGAP;
                    end
                end
            end
            PROW: begin
                op_en_d = 1'b1;
                col_d   = col_q + WB'(1);
                if (col_last) begin
                    col_d   = '0;
                    prow_d  = prow_q + PRB'(1);
                    gcnt_d  = '0;
                    state_d = (32'(prow_q) == PAD_ROWS - 1) ? DRAIN : PGAP;
                end
            end
            DRAIN: begin
                if (done_evt || out_done_q) begin
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge SRST) begin
        if (SRST) begin
            state_q      <= IDLE;
            width_q      <= '0;
            height_q     <= '0;
            col_q        <= '0;
            row_q        <= '0;
            prow_q       <= '0;
            gcnt_q       <= '0;
            orow_q       <= '0;
            ocol_q       <= '0;
            op_en_q      <= 1'b0;
            op_pix_q     <= 1'b0;
            underflow_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            dout_prev_q  <= 1'b0;
            out_done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates make every flop see the pre-edge values of the others.
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            col_q        <= col_d;
            row_q        <= row_d;
            prow_q       <= prow_d;
            gcnt_q       <= gcnt_d;
            orow_q       <= orow_d;
            ocol_q       <= ocol_d;
            op_en_q      <= op_en_d;
            op_pix_q     <= op_pix_d;
            underflow_q  <= underflow_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            dout_prev_q  <= dout_prev_d;
            out_done_q   <= out_done_d;
        end
    end

    assign InReady   = (state_q == ROW);
    assign OpDataEn  = op_en_q;
    assign OpPixel   = op_pix_q;
    assign Busy      = busy_q;
    assign FrameDone = frame_done_q;
    assign Underflow = underflow_q;
    assign OutEn     = out_pass && OpDataOutEn;
    assign OutPixel  = OutEn && OpResult;
    assign OutLast   = OutEn && (ocol_q == width_q - WB'(1));

endmodule

// File: tb/tb_binop_frame_sequencer.sv
// Scoreboard bench for binop_frame_sequencer. The operator model delays rows by PAD rows and
// inverts pixels. A monitor pops the expected results and counts timing events.
module tb_binop_frame_sequencer;
    localparam int WBT   = 11;
    localparam int HBT   = 10;
    localparam int HG    = 20;
    localparam int PAD   = 4;
    localparam int LIMIT = 2000;

    logic clk, SRST, Start, InValid, InPixel, InReady, OpDataEn, OpPixel;
    logic OpDataOutEn, OpResult, OutEn, OutPixel, OutLast, FrameDone, Busy, Underflow;
    logic [WBT-1:0] Width;
    logic [HBT-1:0] Height;

    binop_frame_sequencer #(.WB(WBT), .HB(HBT), .HGAP(HG), .PAD_ROWS(PAD)) dut (
        .clk(clk), .SRST(SRST), .Start(Start), .Width(Width), .Height(Height),
        .InValid(InValid), .InPixel(InPixel), .InReady(InReady),
        .OpDataEn(OpDataEn), .OpPixel(OpPixel), .OpDataOutEn(OpDataOutEn), .OpResult(OpResult),
        .OutEn(OutEn), .OutPixel(OutPixel), .OutLast(OutLast), .FrameDone(FrameDone),
        .Busy(Busy), .Underflow(Underflow)
    );

    typedef struct {
        int oprows, badlen, badgap, padpix, idlepix;
        int ready, outen, outlast, done, bfall, bfall_done;
    } cnt_t;

    cnt_t       cnt;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cur_w, cur_h, op_extra;
    logic [1:0] sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int expd);
        n_checks++;
        if (act !== expd) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expd, $time);
        end
    endtask

    function automatic logic pat(input int r, input int c);
        logic [31:0] row_bits;
        case (r % 4)
            0:       row_bits = 32'hB4E1_96A5;
            1:       row_bits = 32'h5A3C_0FF1;
            2:       row_bits = 32'hC3A5_7E18;
            default: row_bits = 32'h2D69_F00F;
        endcase
        return row_bits[c % 32];
    endfunction

    // Operator model: the output row j carries the inverse of input row j-PAD.
    // Rows before that carry 1s, so leaking them out would be detected.
    initial begin : op_model
        logic [31:0] rows_mem [0:31];
        logic [2:0]  en_sh;
        int          ji, jcol, jd, dcol, tail;
        logic        oen;
        OpDataOutEn = 1'b0; OpResult = 1'b0;
        en_sh = '0; ji = 0; jcol = 0; jd = 0; dcol = 0; tail = 0; oen = 1'b0;
        forever begin
            @(negedge clk);
            if (!Busy) begin
                en_sh = '0; ji = 0; jcol = 0; jd = 0; dcol = 0; tail = 0; oen = 1'b0;
            end else begin
                if (OpDataEn) begin
                    if (ji < 32 && jcol < 32) rows_mem[ji][jcol] = OpPixel;
                    jcol++;
                end else if (jcol != 0) begin
                    ji++;
                    jcol = 0;
                end
                en_sh = {en_sh[1:0], OpDataEn};
                if (en_sh[2]) begin
                    oen = 1'b1; tail = op_extra;
                end else if (tail > 0) begin
                    oen = 1'b1; tail--;
                end else begin
                    if (oen) begin jd++; dcol = 0; end
                    oen = 1'b0;
                end
            end
            OpDataOutEn = oen;
            if (oen) begin
                OpResult = (jd >= PAD && jd - PAD < 32 && dcol < 32) ? ~rows_mem[jd-PAD][dcol] : 1'b1;
                dcol++;
            end else begin
                OpResult = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic       pen, pbusy;
        int         run, gap, orow_i;
        logic [1:0] e;
        pen = 1'b0; pbusy = 1'b0; run = 0; gap = 0; orow_i = 0;
        forever begin
            @(negedge clk);
            #2;
            if (OutEn) begin
                cnt.outen++;
                if (OutLast) cnt.outlast++;
                check("sb_has_entry", int'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("out_pixel", OutPixel, e[1]);
                    check("out_last", OutLast, e[0]);
                end
            end
            if (InReady) cnt.ready++;
            if (FrameDone) cnt.done++;
            if (pbusy && !Busy) begin
                cnt.bfall++;
                if (FrameDone) cnt.bfall_done++;
            end
            pbusy = Busy;
            if (!OpDataEn && OpPixel) cnt.idlepix++;
            if (!Busy) begin
                pen = 1'b0; run = 0; gap = 0; orow_i = 0;
            end else begin
                if (OpDataEn) begin
                    if (!pen && orow_i > 0 && gap != HG) cnt.badgap++;
                    run++;
                    if (orow_i >= cur_h && OpPixel) cnt.padpix++;
                end else begin
                    if (pen) begin
                        cnt.oprows++;
                        if (run != cur_w) cnt.badlen++;
                        orow_i++;
                        run = 0;
                        gap = 0;
                    end
                    gap++;
                end
                pen = OpDataEn;
            end
        end
    end

    task automatic run_frame(input int w, input int h, input int drop_r, input int drop_c,
                             input int extra, input int restart_k, input int restart_w,
                             input int rst_r, input int rst_c, input bit start_at_done,
                             output bit aborted);
        int         r, c, k;
        bit         v;
        logic       pix;
        logic [8:0] outs;
        cur_w = w; cur_h = h; op_extra = extra;
        Width = WBT'(w); Height = HBT'(h); Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        r = 0; c = 0; k = 0; aborted = 1'b0;
        while (!FrameDone && k < LIMIT && !aborted) begin
            if (k == restart_k) begin
                Start = 1'b1; Width = WBT'(restart_w);
            end else begin
                Start = 1'b0;
            end
            InValid = 1'b1; InPixel = 1'b0;
            if (InReady) begin
                if (r == rst_r && c == rst_c) begin
                    check("underflow_before_reset", Underflow, 1);
                    SRST = 1'b1;
                    #1;
                    outs = {InReady, OpDataEn, OpPixel, OutEn, OutPixel, OutLast, FrameDone, Busy, Underflow};
                    check("async_reset_outputs", int'(outs), 0);
                    aborted = 1'b1;
                end else begin
                    pix = pat(r, c);
                    v = !(r == drop_r && c == drop_c);
                    InValid = v; InPixel = pix;
                    sb_q.push_back({~(v & pix), (c == w - 1)});
                    c++;
                    if (c == w) begin c = 0; r++; end
                end
            end
            if (!aborted) @(negedge clk);
            k++;
        end
        Start = 1'b0;
        if (!aborted) begin
            check("frame_done_seen", FrameDone, 1);
            if (start_at_done) begin
                Start = 1'b1; Width = WBT'(5); Height = HBT'(2);
                @(negedge clk);
                Start = 1'b0;
                check("start_at_done_ignored_busy", Busy, 0);
            end
        end
    endtask

    task automatic check_frame(input string t, input cnt_t c0, input int w, input int h, input int uf);
        check({t, "_op_rows"}, cnt.oprows - c0.oprows, h + PAD);
        check({t, "_op_row_len_errs"}, cnt.badlen - c0.badlen, 0);
        check({t, "_op_gap_errs"}, cnt.badgap - c0.badgap, 0);
        check({t, "_pad_row_ones"}, cnt.padpix - c0.padpix, 0);
        check({t, "_idle_ones"}, cnt.idlepix - c0.idlepix, 0);
        check({t, "_inready_cycles"}, cnt.ready - c0.ready, w * h);
        check({t, "_outen_cycles"}, cnt.outen - c0.outen, w * h);
        check({t, "_outlast_count"}, cnt.outlast - c0.outlast, h);
        check({t, "_framedone_cycles"}, cnt.done - c0.done, 1);
        check({t, "_busy_fall_with_done"}, cnt.bfall_done - c0.bfall_done, 1);
        check({t, "_underflow"}, Underflow, uf);
        check({t, "_scoreboard_left"}, sb_q.size(), 0);
    endtask

    initial begin : stimulus
        cnt_t       c0;
        bit         ab;
        logic [8:0] outs;
        cnt = '{default: 0};
        SRST = 1'b1; Start = 1'b0; Width = '0; Height = '0; InValid = 1'b1; InPixel = 1'b0;
        cur_w = 8; cur_h = 4; op_extra = 0;
        repeat (3) @(negedge clk);
        outs = {InReady, OpDataEn, OpPixel, OutEn, OutPixel, OutLast, FrameDone, Busy, Underflow};
        check("reset_outputs", int'(outs), 0);
        SRST = 1'b0;
        @(negedge clk);

        // A: nominal 8x4 frame
        c0 = cnt;
        run_frame(8, 4, -1, -1, 0, -1, 0, -1, -1, 1'b0, ab);
        repeat (2) @(negedge clk);
        check_frame("A", c0, 8, 4, 0);

        // B: InValid dropped at row 1 col 3
        c0 = cnt;
        run_frame(8, 4, 1, 3, 0, -1, 0, -1, -1, 1'b0, ab);
        repeat (2) @(negedge clk);
        check_frame("B", c0, 8, 4, 1);
        repeat (10) @(negedge clk);
        check("underflow_sticky_idle", Underflow, 1);

        // C: 1x1 frame, with Start in the FrameDone cycle; D starts on the next cycle
        c0 = cnt;
        run_frame(1, 1, -1, -1, 0, -1, 0, -1, -1, 1'b1, ab);
        check_frame("C", c0, 1, 1, 0);

        // D: Start with Width=3 mid-frame is ignored; over-long operator rows
        c0 = cnt;
        run_frame(8, 4, -1, -1, 2, 60, 3, -1, -1, 1'b0, ab);
        repeat (2) @(negedge clk);
        check_frame("D", c0, 8, 4, 0);

        // E: reset during row 2 aborts the frame with no FrameDone
        c0 = cnt;
        run_frame(6, 5, 0, 1, 0, -1, 0, 2, 3, 1'b0, ab);
        repeat (2) @(negedge clk);
        check("E_aborted", int'(ab), 1);
        check("E_framedone_cycles", cnt.done - c0.done, 0);
        check("E_busy_fall", cnt.bfall - c0.bfall, 1);
        check("E_busy_fall_with_done", cnt.bfall_done - c0.bfall_done, 0);
        SRST = 1'b0;
        sb_q.delete();
        repeat (3) @(negedge clk);

        // F: clean frame after the abort
        c0 = cnt;
        run_frame(8, 4, -1, -1, 0, -1, 0, -1, -1, 1'b0, ab);
        repeat (2) @(negedge clk);
        check_frame("F", c0, 8, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
